// File: rtl/data_mover_bram_mul_n.sv
// Streams N words from BRAM0 through NUM_CORE parallel multiply lanes into BRAM1.
// Independent read and write FSMs; writes trail reads by 1+MUL_LAT cycles.
module data_mover_bram_mul_n #(
   parameter int CNT_BIT       = 31,
   parameter int AWIDTH        = 12,
   parameter int NUM_CORE      = 4,
   parameter int IN_DATA_WIDTH = 8,
   parameter int MUL_LAT       = 1
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                i_run,
   input  logic [CNT_BIT-1:0]                  i_num_cnt,
   input  logic [AWIDTH-1:0]                   i_src_base,
   input  logic [AWIDTH-1:0]                   i_dst_base,
   input  logic                                i_signed,
   output logic                                o_idle,
   output logic                                o_read,
   output logic                                o_write,
   output logic                                o_done,
   output logic [AWIDTH-1:0]                   addr_b0,
   output logic                                ce_b0,
   output logic                                we_b0,
   output logic [2*NUM_CORE*IN_DATA_WIDTH-1:0] d_b0,
   input  logic [2*NUM_CORE*IN_DATA_WIDTH-1:0] q_b0,
   output logic [AWIDTH-1:0]                   addr_b1,
   output logic                                ce_b1,
   output logic                                we_b1,
   output logic [2*NUM_CORE*IN_DATA_WIDTH-1:0] d_b1,
   input  logic [2*NUM_CORE*IN_DATA_WIDTH-1:0] q_b1
);

   localparam int W      = IN_DATA_WIDTH;
   localparam int DWIDTH = 2 * NUM_CORE * IN_DATA_WIDTH;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             rdState_q, rdState_d;
   state_t             wrState_q, wrState_d;
   logic [CNT_BIT-1:0] numCnt_q;
   logic [CNT_BIT-1:0] rdCnt_q, rdCnt_d;
   logic [CNT_BIT-1:0] wrCnt_q, wrCnt_d;
   logic [AWIDTH-1:0]  srcBase_q, dstBase_q;
   logic               signed_q;
   logic               rdValid_q;
   logic [MUL_LAT-1:0] validPipe_q;
   logic [DWIDTH-1:0]  prodPipe_q [MUL_LAT];
   logic [DWIDTH-1:0]  prodComb;
   logic [W-1:0]       aOp, bOp;
   logic [2*W-1:0]     aExt, bExt;
   logic               accept, rdLast, wrLast, resValid;
   logic               unusedQb1;

   assign unusedQb1 = ^q_b1;

   assign o_idle   = (rdState_q == IDLE) && (wrState_q == IDLE);
   assign o_read   = (rdState_q == RUN);
   assign o_write  = (wrState_q == RUN);
   assign o_done   = (wrState_q == DONE);
   assign accept   = i_run && o_idle;
   assign resValid = validPipe_q[MUL_LAT-1];
   assign rdLast   = (rdCnt_q + CNT_BIT'(1)) == numCnt_q;
   assign wrLast   = resValid && ((wrCnt_q + CNT_BIT'(1)) == numCnt_q);

   assign addr_b0 = srcBase_q + AWIDTH'(rdCnt_q);
   assign ce_b0   = o_read;
   assign we_b0   = 1'b0;
   assign d_b0    = '0;
   assign addr_b1 = dstBase_q + AWIDTH'(wrCnt_q);
   assign ce_b1   = resValid;
   assign we_b1   = resValid;
   assign d_b1    = prodPipe_q[MUL_LAT-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         numCnt_q  <= '0;
         srcBase_q <= '0;
         dstBase_q <= '0;
         signed_q  <= 1'b0;
      end else if (accept) begin
         numCnt_q  <= i_num_cnt;
         srcBase_q <= i_src_base;
         dstBase_q <= i_dst_base;
         signed_q  <= i_signed;
      end else if (o_done) begin
         numCnt_q  <= '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdState_q <= IDLE;
         wrState_q <= IDLE;
         rdCnt_q   <= '0;
         wrCnt_q   <= '0;
      end else begin
         rdState_q <= rdState_d;
         wrState_q <= wrState_d;
         rdCnt_q   <= rdCnt_d;
         wrCnt_q   <= wrCnt_d;
      end
   end

   always_comb begin
      rdState_d = rdState_q;
      rdCnt_d   = rdCnt_q;
      case (rdState_q)
         IDLE: begin
            rdCnt_d = '0;
            if (accept) rdState_d = (i_num_cnt == '0) ? DONE : RUN;
         end
         RUN: begin
            if (rdLast) begin
               rdState_d = DONE;
               rdCnt_d   = '0;
            end else begin
               rdCnt_d = rdCnt_q + CNT_BIT'(1);
            end
         end
         DONE:    rdState_d = IDLE;
         default: rdState_d = IDLE;
      endcase
   end

   // The write side counts completed results, not cycles, so it tolerates gaps in the stream.
   always_comb begin
      wrState_d = wrState_q;
      wrCnt_d   = wrCnt_q;
      case (wrState_q)
         IDLE: begin
            wrCnt_d = '0;
            if (accept) wrState_d = (i_num_cnt == '0) ? DONE : RUN;
         end
         RUN: begin
            if (wrLast) begin
               wrState_d = DONE;
               wrCnt_d   = '0;
            end else if (resValid) begin
               wrCnt_d = wrCnt_q + CNT_BIT'(1);
            end
         end
         DONE:    wrState_d = IDLE;
         default: wrState_d = IDLE;
      endcase
   end

   // Extending to 2W bits before multiplying keeps the product exact in both modes.
   always_comb begin
      prodComb = '0;
      aOp      = '0;
      bOp      = '0;
      aExt     = '0;
      bExt     = '0;
      for (int i = 0; i < NUM_CORE; i++) begin
         aOp  = q_b0[2*i*W +: W];
         bOp  = q_b0[(2*i+1)*W +: W];
         aExt = signed_q ? {{W{aOp[W-1]}}, aOp} : {{W{1'b0}}, aOp};
         bExt = signed_q ? {{W{bOp[W-1]}}, bOp} : {{W{1'b0}}, bOp};
         prodComb[2*i*W +: 2*W] = aExt * bExt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdValid_q   <= 1'b0;
         validPipe_q <= '0;
         for (int k = 0; k < MUL_LAT; k++) prodPipe_q[k] <= '0;
      end else begin
         rdValid_q      <= o_read;
         validPipe_q[0] <= rdValid_q;
         prodPipe_q[0]  <= prodComb;
         for (int k = 1; k < MUL_LAT; k++) begin
            validPipe_q[k] <= validPipe_q[k-1];
            prodPipe_q[k]  <= prodPipe_q[k-1];
         end
      end
   end

endmodule

// File: doc/data_mover_bram_mul_n.md
DATA_MOVER_BRAM_MUL_N -- requirements
Module: data_mover_bram_mul_n

Interface
REQ-001 SHALL have parameter CNT_BIT, default 31, width of the transfer-count input and internal counters.
REQ-002 SHALL have parameter AWIDTH, default 12, BRAM address width.
REQ-003 SHALL have parameter NUM_CORE, default 4, number of parallel multiply lanes (legal values 1..16).
REQ-004 SHALL have parameter IN_DATA_WIDTH, default 8, operand width per lane.
REQ-005 SHALL have parameter MUL_LAT, default 1, multiplier pipeline depth in cycles (legal values 1..4); DWIDTH is derived as 2*NUM_CORE*IN_DATA_WIDTH.
REQ-006 SHALL have the following ports, in this order:
- clk  in  1  single clock; all logic on the rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- i_run  in  1  start pulse.
- i_num_cnt  in  CNT_BIT  number of words to process.
- i_src_base  in  AWIDTH  BRAM0 start address.
- i_dst_base  in  AWIDTH  BRAM1 start address.
- i_signed  in  1  1 = signed (two's complement) multiply, 0 = unsigned.
- o_idle  out  1  both FSMs are in IDLE.
- o_read  out  1  read FSM is in RUN.
- o_write  out  1  write FSM is in RUN.
- o_done  out  1  one-cycle completion pulse.
- addr_b0 / ce_b0 / we_b0 / d_b0 / q_b0  out AWIDTH / out 1 / out 1 / out DWIDTH / in DWIDTH  BRAM0 port, read only.
- addr_b1 / ce_b1 / we_b1 / d_b1 / q_b1  out AWIDTH / out 1 / out 1 / out DWIDTH / in DWIDTH  BRAM1 port, write only; q_b1 is unused.

Function
REQ-007 SHALL implement independent read and write FSMs, each with states IDLE, RUN and DONE.
- IDLE->RUN on an accepted i_run.
- RUN->DONE on the last beat.
- DONE->IDLE unconditionally.
REQ-008 SHALL accept i_run only while o_idle=1, capturing i_num_cnt, both bases and i_signed; i_run while busy SHALL be ignored and SHALL NOT alter any captured value.
REQ-009 SHALL, for captured count 0, move both FSMs IDLE->DONE->IDLE, pulse o_done in the cycle after i_run, and assert no ce/we.
REQ-010 SHALL, in read RUN beat k (k = 0..N-1), drive addr_b0 = src_base+k modulo 2^AWIDTH, with ce_b0=1 and we_b0=0; d_b0 SHALL be 0.
REQ-011 SHALL treat q_b0 as valid one cycle after the cycle in which ce_b0 was asserted (valid flag registered from o_read).
REQ-012 SHALL split each word into per-lane operands and results for lane i:
- a_i = q_b0[(2i+1)W-1 : 2iW].
- b_i = q_b0[(2i+2)W-1 : (2i+1)W].
- result_i = a_i*b_i, 2W bits, placed at d_b1[(2i+2)W-1 : 2iW], where W = IN_DATA_WIDTH.
REQ-013 SHALL sign-extend operands when the captured i_signed=1 and zero-extend them otherwise; the product SHALL be exact with no truncation.
REQ-014 SHALL register the product through exactly MUL_LAT stages, with all lanes sharing one valid pipeline.
REQ-015 SHALL drive ce_b1 = we_b1 = the result-valid signal, with addr_b1 = dst_base + write_count modulo 2^AWIDTH.
REQ-016 SHALL increment write_count only on we_b1=1 and clear it on the last write; the write FSM SHALL leave RUN on the cycle of write N-1.
REQ-017 SHALL produce write beat k exactly 1+MUL_LAT cycles after read beat k, with no gaps when reads are contiguous.
REQ-018 SHALL assert o_done only in write DONE (exactly one cycle); read DONE SHALL NOT assert o_done.
REQ-019 SHALL clear the captured count on o_done; address counters SHALL wrap silently with no error indication.

Reset
REQ-020 SHALL, while reset_n=0 (asynchronous, at any time including mid-transfer), force:
- both FSMs to IDLE.
- all counters, captured values and the valid pipeline to 0.
- o_idle=1; o_read, o_write, o_done, ce_b0, ce_b1 and we_b1 all 0.
REQ-021 SHALL NOT issue any BRAM write after reset release until a new i_run is accepted.

Verification
REQ-022 Defaults, i_run at cycle 0 with N=4, src=0x010, dst=0x100, unsigned -> reads at 0x010..0x013 in cycles 1..4; writes at 0x100..0x103 in cycles 3..6; o_done=1 in cycle 7 only; o_idle=1 in cycle 8.
REQ-023 q_b0=0x0807060504030201, unsigned -> d_b1=0x0038001E000C0002.
REQ-024 Lane 0 with a=0xFF, b=0x02 -> signed gives result_0=0xFFFE; unsigned gives result_0=0x01FE.
REQ-025 src=0xFFE, dst=0xFFF, N=4 -> addr_b0 sequence 0xFFE, 0xFFF, 0x000, 0x001; addr_b1 sequence 0xFFF, 0x000, 0x001, 0x002.
REQ-026 N=0 -> o_done pulses at cycle 1 and no ce is asserted; i_run repeated during RUN -> ignored, exactly N writes occur.
REQ-027 reset_n=0 at read beat 2 -> all outputs at reset values immediately; after release, no writes occur and o_idle=1; a new i_run with N=2 completes normally.
